uart_rx_ovs: RTL and testbench

Parametrised oversampling UART receiver: the next-generation replacement for `uart_rx` in the UART peripheral. It samples a 2-FF-synchronised `rx` line at a runtime-programmable oversample ratio and decodes 5–9 data bits, none/even/odd parity and 1 or 2 stop bits. Received words and their per-frame error flags go into an internal FIFO with a valid/ready pop interface; break and overrun are reported separately. It sits between the pad synchroniser domain and the peripheral's packet/host interface logic.

---
 rtl/uart_rx_ovs.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with a small receive FIFO. Encodings: parity 0=NONE 1=EVEN 2=ODD,
// stop_bits 0=one 1=two. Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module uart_rx_ovs #(
  parameter int MAX_DATA_BITS = 9,
  parameter int RATIO_W       = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  input  logic [3:0]               num_data_bits,
  input  logic [1:0]               parity,
  input  logic                     stop_bits,
  input  logic [RATIO_W-1:0]       rx_tx_clk_ratio,
  output logic [MAX_DATA_BITS-1:0] rx_data,
  output logic                     rx_parity_err,
  output logic                     rx_frame_err,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     rx_full,
  output logic                     rx_busy,
  output logic                     rx_done,
  output logic                     rx_overrun,
  output logic                     rx_break
);
  localparam logic [1:0] P_NONE = 2'd0;
  localparam logic [1:0] P_ODD  = 2'd2;
  localparam logic [RATIO_W-1:0] ONE = 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = MAX_DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  state_t st, st_n;

  logic rx_s1, rx_s2, rx_d;
  logic [RATIO_W-1:0] cnt, ratio_q, mid;
  logic [3:0] nbits_q, bit_idx;
  logic [1:0] par_q;
  logic stop_q;
  logic [MAX_DATA_BITS-1:0] shreg;
  logic perr, ferr, all_zero;
  logic start_det, smp, bit_v, frame_end, brk, push, pop, push_ok, frm_fin;

  logic [FIFO_DEPTH-1:0][EW-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign start_det = rx_d & ~rx_s2;
  assign mid       = ratio_q >> 1;

`ifdef UART_RX_MAJORITY_EN
  logic s_a, s_b;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else begin
      if (cnt == mid - ONE) s_a <= rx_s2;
      if (cnt == mid)       s_b <= rx_s2;
    end
  end
  assign smp   = (cnt == mid + ONE);
  assign bit_v = (s_a & s_b) | (s_a & rx_s2) | (s_b & rx_s2);
`else
  assign smp   = (cnt == mid);
  assign bit_v = rx_s2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= st_n;
  end

  always_comb begin
    st_n      = st;
    frame_end = 1'b0;
    case (st)
      IDLE:      if (start_det) st_n = START;
      START:     if (smp) st_n = bit_v ? IDLE : DATA;
      DATA:      if (smp && bit_idx == nbits_q - 4'd1) st_n = (par_q != P_NONE) ? PARITY : STOP;
      PARITY:    if (smp) st_n = STOP;
      STOP:      if (smp && bit_idx == {3'd0, stop_q}) begin
                   frame_end = 1'b1;
                   st_n      = (bit_v && !(all_zero)) ? IDLE : WAIT_IDLE;
                 end
      WAIT_IDLE: if (rx_s2) st_n = IDLE;
      default:   st_n = IDLE;
    endcase
  end

  // Break needs every data/parity/stop sample low, including the one being taken now.
  assign brk     = frame_end & all_zero & ~bit_v;
  assign push    = frame_end & ~brk;
  assign frm_fin = ferr | ~bit_v;
  assign pop     = rx_valid & rx_ready;
  assign push_ok = push & (~rx_full | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0; ratio_q <= '0; nbits_q <= '0; par_q <= '0; stop_q <= 1'b0;
      shreg <= '0; perr <= 1'b0; ferr <= 1'b0; all_zero <= 1'b1; bit_idx <= '0;
    end else if (st == IDLE) begin
      // Counter starts at 1: the detection cycle is count 0 of the start bit.
      cnt <= ONE; shreg <= '0; perr <= 1'b0; ferr <= 1'b0; all_zero <= 1'b1; bit_idx <= '0;
      if (start_det) begin
        ratio_q <= rx_tx_clk_ratio;
        nbits_q <= num_data_bits;
        par_q   <= parity;
        stop_q  <= stop_bits;
      end
    end else begin
      cnt <= (cnt == ratio_q - ONE) ? '0 : cnt + ONE;
      if (smp) begin
        case (st)
          DATA: begin
            shreg[bit_idx] <= bit_v;
            all_zero       <= all_zero & ~bit_v;
            bit_idx        <= (st_n == DATA) ? bit_idx + 4'd1 : 4'd0;
          end
          PARITY: begin
            perr     <= (^shreg) ^ bit_v ^ (par_q == P_ODD);
            all_zero <= all_zero & ~bit_v;
          end
          STOP: begin
            ferr     <= ferr | ~bit_v;
            all_zero <= all_zero & ~bit_v;
            bit_idx  <= bit_idx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_done <= 1'b0; rx_overrun <= 1'b0; rx_break <= 1'b0;
    end else begin
      rx_done    <= push;
      rx_overrun <= push & ~push_ok;
      rx_break   <= brk;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0; wr_ptr <= '0; rd_ptr <= '0; fcnt <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {shreg, perr, frm_fin};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign {rx_data, rx_parity_err, rx_frame_err} = mem[rd_ptr];
  assign rx_valid = (fcnt != '0);
  assign rx_full  = (fcnt == (AW+1)'(FIFO_DEPTH));
  assign rx_busy  = (st != IDLE);
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: frame formats, errors, break, overrun, glitch and reset abort.
module tb_uart_rx_ovs;
  localparam logic [1:0] P_NONE = 2'd0, P_EVEN = 2'd1, P_ODD = 2'd2;

  logic clk = 1'b0, rst = 1'b0, rx = 1'b1, rx_ready = 1'b0, stop_bits = 1'b0;
  logic [3:0] num_data_bits = 4'd8;
  logic [1:0] parity = P_NONE;
  logic [7:0] rx_tx_clk_ratio = 8'd8;
  logic [8:0] rx_data;
  logic rx_parity_err, rx_frame_err, rx_valid, rx_full, rx_busy, rx_done, rx_overrun, rx_break;

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, brk_cnt = 0, ovr_cnt = 0;
  int exp_done = 0;

  uart_rx_ovs dut (
    .clk(clk), .rst(rst), .rx(rx), .num_data_bits(num_data_bits), .parity(parity),
    .stop_bits(stop_bits), .rx_tx_clk_ratio(rx_tx_clk_ratio), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_full(rx_full), .rx_busy(rx_busy), .rx_done(rx_done),
    .rx_overrun(rx_overrun), .rx_break(rx_break)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done)    done_cnt++;
    if (rx_break)   brk_cnt++;
    if (rx_overrun) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_time(input logic b, input int r, input int g);
    for (int s = 0; s < r; s++) begin
      rx = (s == g) ? ~b : b;
      @(negedge clk);
    end
  endtask

  // gbit numbers frame bits with 0 = start; gslot inverts one oversample slot of that bit.
  task automatic send_frame(input logic [8:0] d, input int nb, input logic [1:0] par,
                            input logic flip_par, input int nstop, input logic last_stop,
                            input int r, input int gbit, input int gslot);
    logic pb;
    num_data_bits   = 4'(nb);
    parity          = par;
    stop_bits       = (nstop == 2);
    rx_tx_clk_ratio = 8'(r);
    pb = 1'b0;
    for (int i = 0; i < nb; i++) pb ^= d[i];
    if (par == P_ODD) pb = ~pb;
    pb ^= flip_par;
    bit_time(1'b0, r, -1);
    for (int i = 0; i < nb; i++) bit_time(d[i], r, (gbit == i + 1) ? gslot : -1);
    if (par != P_NONE) bit_time(pb, r, -1);
    if (nstop == 2) bit_time(1'b1, r, -1);
    bit_time(last_stop, r, -1);
  endtask

  task automatic pop_chk(input string tag, input logic [8:0] d, input logic pe, input logic fe);
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    check({tag, "_data"}, 32'(rx_data), 32'(d));
    check({tag, "_perr"}, 32'(rx_parity_err), 32'(pe));
    check({tag, "_ferr"}, 32'(rx_frame_err), 32'(fe));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_full", 32'(rx_full), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_pulses", 32'({rx_done, rx_overrun, rx_break}), 32'd0);
    rst = 1'b1;
    idle(8);

    // 8E1 ratio 8, good parity
    send_frame(9'h0B1, 8, P_EVEN, 1'b0, 1, 1'b1, 8, -1, 0); exp_done++;
    idle(8);
    check("t1_done", 32'(done_cnt), 32'(exp_done));
    pop_chk("t1", 9'h0B1, 1'b0, 1'b0);
    check("t1_empty", 32'(rx_valid), 32'd0);

    // same frame, parity bit inverted
    send_frame(9'h0B1, 8, P_EVEN, 1'b1, 1, 1'b1, 8, -1, 0); exp_done++;
    idle(8);
    pop_chk("t2", 9'h0B1, 1'b1, 1'b0);

    // 7O2 ratio 16, second stop low: framing error, then held in WAIT_IDLE
    send_frame(9'h055, 7, P_ODD, 1'b0, 2, 1'b0, 16, -1, 0); exp_done++;
    repeat (32) @(negedge clk);
    check("t3_done", 32'(done_cnt), 32'(exp_done));
    check("t3_wait_busy", 32'(rx_busy), 32'd1);
    idle(8);
    check("t3_idle_busy", 32'(rx_busy), 32'd0);
    pop_chk("t3", 9'h055, 1'b0, 1'b1);

    // break: 12 bit times low at 8N1
    num_data_bits = 4'd8; parity = P_NONE; stop_bits = 1'b0; rx_tx_clk_ratio = 8'd8;
    rx = 1'b0;
    repeat (96) @(negedge clk);
    check("brk_cnt", 32'(brk_cnt), 32'd1);
    check("brk_nodone", 32'(done_cnt), 32'(exp_done));
    check("brk_valid", 32'(rx_valid), 32'd0);
    check("brk_busy", 32'(rx_busy), 32'd1);
    idle(8);
    check("brk_idle", 32'(rx_busy), 32'd0);

    // overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(9'(i), 8, P_NONE, 1'b0, 1, 1'b1, 8, -1, 0); exp_done++;
      idle(8);
      if (i == 4) begin
        check("ovr_full4", 32'(rx_full), 32'd1);
        check("ovr_none4", 32'(ovr_cnt), 32'd0);
      end
    end
    check("ovr_cnt", 32'(ovr_cnt), 32'd1);
    check("ovr_done", 32'(done_cnt), 32'(exp_done));
    for (int i = 1; i <= 4; i++) pop_chk("ovr_pop", 9'(i), 1'b0, 1'b0);
    check("ovr_empty", 32'(rx_valid), 32'd0);
    check("ovr_notfull", 32'(rx_full), 32'd0);

    // 2-cycle low glitch: false start
    rx = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    check("gl_busy_rise", 32'(rx_busy), 32'd1);
    idle(16);
    check("gl_busy_clr", 32'(rx_busy), 32'd0);
    check("gl_nodone", 32'(done_cnt), 32'(exp_done));
    check("gl_valid", 32'(rx_valid), 32'd0);

    // boundaries: 5 data bits zero-extended, 9 data bits at minimum ratio
    send_frame(9'h013, 5, P_EVEN, 1'b0, 1, 1'b1, 5, -1, 0); exp_done++;
    idle(8);
    pop_chk("b5", 9'h013, 1'b0, 1'b0);
    send_frame(9'h1A5, 9, P_NONE, 1'b0, 1, 1'b1, 4, -1, 0); exp_done++;
    idle(8);
    pop_chk("b9", 9'h1A5, 1'b0, 1'b0);

`ifdef UART_RX_MAJORITY_EN
    // single-slot glitch at the mid sample of data bit 3 is voted out
    send_frame(9'h05A, 8, P_NONE, 1'b0, 1, 1'b1, 8, 4, 4); exp_done++;
    idle(8);
    pop_chk("maj", 9'h05A, 1'b0, 1'b0);
`endif

    // reset in the middle of a frame
    num_data_bits = 4'd8; parity = P_NONE; stop_bits = 1'b0; rx_tx_clk_ratio = 8'd8;
    bit_time(1'b0, 8, -1);
    bit_time(1'b1, 8, -1);
    bit_time(1'b1, 8, -1);
    check("rm_busy", 32'(rx_busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rm_busy_clr", 32'(rx_busy), 32'd0);
    rst = 1'b1;
    idle(100);
    check("rm_nodone", 32'(done_cnt), 32'(exp_done));
    check("rm_valid", 32'(rx_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
